// File: rtl/regbank_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM encoding and
// default bank geometry.
package regbank_pkg;

    localparam int REGBANK_W  = 4;
    localparam int REGBANK_N  = 4;
    localparam int REGBANK_AW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        WRITE = 2'b10
    } state_t;

endpackage

// File: rtl/regbank_arbiter_if.sv
// Requester/bank-side bundle of the arbiter. The master side is the pair of
// requesters (plus whoever watches the bank outputs); the slave side is the
// arbiter itself.
interface regbank_arbiter_if
    import regbank_pkg::*;
#(
    parameter int W = REGBANK_W,
    parameter int N = REGBANK_N
);
    localparam int AW = $clog2(N);

    logic          req0;
    logic [AW-1:0] addr0;
    logic [W-1:0]  data0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic [W-1:0]  data1;
    logic          gnt0;
    logic          gnt1;
    logic [N-1:0]  we;
    logic [W-1:0]  wdata;
    logic          busy;
    logic [3:0]    wr_count;

    modport master (
        output req0, addr0, data0, req1, addr1, data1,
        input  gnt0, gnt1, we, wdata, busy, wr_count
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1,
        output gnt0, gnt1, we, wdata, busy, wr_count
    );

endinterface

// File: rtl/regbank_arbiter_rr_pick2.sv
// Two-way round-robin pick. A lone request wins outright; on a tie the
// requester named by prio wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic valid,
    output logic winner
);

    // Pure combinational choice; winner is meaningless when valid is low.
    always_comb begin
        valid  = req0 | req1;
        winner = req1 & (~req0 | prio);
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin write arbiter for a small bank of enable-gated registers.
// Each transaction runs IDLE -> GRANT -> WRITE -> IDLE: one grant cycle,
// one write-enable cycle, then the completed-write counter advances.
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int W = REGBANK_W,
    parameter int N = REGBANK_N
) (
    input  logic              clk,
    input  logic              rst,
    regbank_arbiter_if.slave  bus
);

    localparam int AW = $clog2(N);

    state_t         state_reg, state_next;
    logic           gnt0_reg, gnt0_next;
    logic           gnt1_reg, gnt1_next;
    logic [N-1:0]   we_reg, we_next;
    logic [W-1:0]   wdata_reg, wdata_next;
    logic [3:0]     wr_count_reg, wr_count_next;
    logic           prio_reg, prio_next;
    logic           winner_reg, winner_next;

    logic           pick_valid;
    logic           pick_winner;
    logic           sel_req;
    logic [AW-1:0]  sel_addr;
    logic [W-1:0]   sel_data;
    logic [N-1:0]   we_decode;

    rr_pick2 u_pick (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .prio   (prio_reg),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // The granted requester's lines, steered by the winner latched in IDLE.
    always_comb begin
        sel_req  = winner_reg ? bus.req1  : bus.req0;
        sel_addr = winner_reg ? bus.addr1 : bus.addr0;
        sel_data = winner_reg ? bus.data1 : bus.data0;
    end

    // One-hot decode of the captured address into per-register enables.
    for (genvar gi = 0; gi < N; gi++) begin : g_we_decode
        assign we_decode[gi] = (sel_addr == AW'(gi));
    end

    // Next-state and next-output logic; everything defaults to hold, except
    // grants and write enables which are single-cycle pulses.
    always_comb begin
        state_next    = state_reg;
        gnt0_next     = 1'b0;
        gnt1_next     = 1'b0;
        we_next       = '0;
        wdata_next    = wdata_reg;
        wr_count_next = wr_count_reg;
        prio_next     = prio_reg;
        winner_next   = winner_reg;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next  = GRANT;
                    winner_next = pick_winner;
                    gnt0_next   = ~pick_winner;
                    gnt1_next   = pick_winner;
                end
            end
            GRANT: begin
                // Requester still asking: commit. Otherwise the request was
                // withdrawn and the slot is abandoned without side effects.
                if (sel_req) begin
                    wdata_next = sel_data;
                    we_next    = we_decode;
                    state_next = WRITE;
                end else begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                wr_count_next = wr_count_reg + 4'd1;
                prio_next     = ~winner_reg;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            gnt0_reg     <= 1'b0;
            gnt1_reg     <= 1'b0;
            we_reg       <= '0;
            wdata_reg    <= '0;
            wr_count_reg <= 4'd0;
            prio_reg     <= 1'b0;
            winner_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gnt0_reg     <= gnt0_next;
            gnt1_reg     <= gnt1_next;
            we_reg       <= we_next;
            wdata_reg    <= wdata_next;
            wr_count_reg <= wr_count_next;
            prio_reg     <= prio_next;
            winner_reg   <= winner_next;
        end
    end

    assign bus.gnt0     = gnt0_reg;
    assign bus.gnt1     = gnt1_reg;
    assign bus.we       = we_reg;
    assign bus.wdata    = wdata_reg;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.wr_count = wr_count_reg;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for the register-bank write arbiter.
module tb_regbank_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    regbank_arbiter_if #(.W(4), .N(4)) bus ();

    regbank_arbiter #(.W(4), .N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle so registered outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0 = 1'b0; bus.addr0 = 2'd0; bus.data0 = 4'h0;
        bus.req1 = 1'b0; bus.addr1 = 2'd0; bus.data1 = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({bus.gnt0, bus.gnt1, bus.we, bus.wdata, bus.busy, bus.wr_count} !== 15'd0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got gnt=%b%b we=%b wdata=%h busy=%b cnt=%0d want all zero",
                         i, bus.gnt0, bus.gnt1, bus.we, bus.wdata, bus.busy, bus.wr_count);
            end
        end
        $display("reset: idle checked for 5 cycles");
    endtask

    task automatic test_contention();
        bus.req0 = 1'b1; bus.addr0 = 2'd0; bus.data0 = 4'h3;
        bus.req1 = 1'b1; bus.addr1 = 2'd3; bus.data1 = 4'h5;
        tick();  // E
        total++;
        if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b101) begin
            bad++;
            $display("FAIL cont_gnt0 got gnt0=%b gnt1=%b busy=%b want 1 0 1", bus.gnt0, bus.gnt1, bus.busy);
        end
        tick();  // E+1
        total++;
        if (bus.we !== 4'b0001 || bus.wdata !== 4'h3 || bus.gnt0 !== 1'b0) begin
            bad++;
            $display("FAIL cont_w0 got we=%b wdata=%h gnt0=%b want 0001 3 0", bus.we, bus.wdata, bus.gnt0);
        end
        bus.req0 = 1'b0;
        tick();  // E+2
        total++;
        if (bus.wr_count !== 4'd1 || bus.we !== 4'b0000 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL cont_done0 got cnt=%0d we=%b busy=%b want 1 0000 0", bus.wr_count, bus.we, bus.busy);
        end
        tick();  // E+3
        total++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            bad++;
            $display("FAIL cont_gnt1 got gnt0=%b gnt1=%b want 0 1", bus.gnt0, bus.gnt1);
        end
        tick();  // E+4
        total++;
        if (bus.we !== 4'b1000 || bus.wdata !== 4'h5) begin
            bad++;
            $display("FAIL cont_w1 got we=%b wdata=%h want 1000 5", bus.we, bus.wdata);
        end
        bus.req1 = 1'b0;
        tick();  // E+5
        total++;
        if (bus.wr_count !== 4'd2 || dut.prio_reg !== 1'b0) begin
            bad++;
            $display("FAIL cont_final got cnt=%0d prio=%b want 2 0", bus.wr_count, dut.prio_reg);
        end
        $display("contention: req0 then req1 serviced, cnt=%0d", bus.wr_count);
    endtask

    task automatic test_single();
        bus.req0 = 1'b1; bus.addr0 = 2'd2; bus.data0 = 4'hA;
        tick();  // E
        total++;
        if (bus.gnt0 !== 1'b1 || bus.we !== 4'b0000) begin
            bad++;
            $display("FAIL single_gnt got gnt0=%b we=%b want 1 0000", bus.gnt0, bus.we);
        end
        tick();  // E+1
        total++;
        if (bus.we !== 4'b0100 || bus.wdata !== 4'hA || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_we got we=%b wdata=%h busy=%b want 0100 a 1", bus.we, bus.wdata, bus.busy);
        end
        bus.req0 = 1'b0;
        tick();  // E+2
        total++;
        if (bus.wr_count !== 4'd3 || dut.prio_reg !== 1'b1 || bus.we !== 4'b0000) begin
            bad++;
            $display("FAIL single_done got cnt=%0d prio=%b we=%b want 3 1 0000", bus.wr_count, dut.prio_reg, bus.we);
        end
        $display("single: req0 addr=2 data=a cnt=%0d", bus.wr_count);
    endtask

    task automatic test_abort();
        bus.req1 = 1'b1; bus.addr1 = 2'd1; bus.data1 = 4'hF;
        tick();  // E
        total++;
        if (bus.gnt1 !== 1'b1) begin
            bad++;
            $display("FAIL abort_gnt got gnt1=%b want 1", bus.gnt1);
        end
        bus.req1 = 1'b0;
        tick();  // E+1
        total++;
        if (bus.we !== 4'b0000 || bus.gnt1 !== 1'b0 || bus.busy !== 1'b0 || bus.wdata !== 4'hA) begin
            bad++;
            $display("FAIL abort_out got we=%b gnt1=%b busy=%b wdata=%h want 0000 0 0 a",
                     bus.we, bus.gnt1, bus.busy, bus.wdata);
        end
        tick();
        total++;
        if (bus.wr_count !== 4'd3 || dut.prio_reg !== 1'b1 || bus.we !== 4'b0000 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_state got cnt=%0d prio=%b we=%b busy=%b want 3 1 0000 0",
                     bus.wr_count, dut.prio_reg, bus.we, bus.busy);
        end
        $display("abort: req1 withdrawn, cnt=%0d", bus.wr_count);
    endtask

    task automatic test_reset_mid();
        bus.req0 = 1'b1; bus.addr0 = 2'd1; bus.data0 = 4'h6;
        tick();  // E: GRANT
        tick();  // E+1: WRITE, we high
        total++;
        if (bus.we !== 4'b0010) begin
            bad++;
            $display("FAIL rstmid_we got we=%b want 0010", bus.we);
        end
        rst = 1'b1;
        tick();  // reset sampled during WRITE
        total++;
        if ({bus.gnt0, bus.gnt1, bus.we, bus.wdata, bus.busy, bus.wr_count} !== 15'd0 || dut.prio_reg !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_clear got gnt=%b%b we=%b wdata=%h busy=%b cnt=%0d prio=%b want all zero",
                     bus.gnt0, bus.gnt1, bus.we, bus.wdata, bus.busy, bus.wr_count, dut.prio_reg);
        end
        rst = 1'b0;
        tick();  // pending req0 granted again
        total++;
        if (bus.gnt0 !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_regrant got gnt0=%b want 1", bus.gnt0);
        end
        tick();
        bus.req0 = 1'b0;
        tick();
        total++;
        if (bus.wr_count !== 4'd1) begin
            bad++;
            $display("FAIL rstmid_cnt got cnt=%0d want 1", bus.wr_count);
        end
        $display("reset_mid: cleared and regranted, cnt=%0d", bus.wr_count);
    endtask

    task automatic test_wrap();
        logic [1:0] a;
        logic [3:0] d;
        logic [3:0] exp_we;
        logic [3:0] exp_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            a = 2'(i);
            d = 4'(i * 3);
            exp_we = 4'b0001 << a;
            exp_cnt = 4'(i);
            bus.req0 = 1'b1; bus.addr0 = a; bus.data0 = d;
            tick();
            tick();
            total++;
            if (bus.we !== exp_we || bus.wdata !== d) begin
                bad++;
                $display("FAIL wrap_we n=%0d got we=%b wdata=%h want %b %h", i, bus.we, bus.wdata, exp_we, d);
            end
            bus.req0 = 1'b0;
            tick();
            total++;
            if (bus.wr_count !== exp_cnt) begin
                bad++;
                $display("FAIL wrap_cnt n=%0d got cnt=%0d want %0d", i, bus.wr_count, exp_cnt);
            end
            $display("wrap: write %0d cnt=%0d", i, bus.wr_count);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_contention();
        test_single();
        test_abort();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
